// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and end-of-simulation defaults for dm_lsu
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_LOAD_RSP,
        S_STORE_RSP,
        S_ERR_RSP
    } state_t;

    localparam logic [13:0] SIM_END_WADDR_DEF = 14'h3FFF;
    localparam logic [31:0] SIM_END_CODE_DEF  = 32'hFFFF_FFFF;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane shift / byte-enable generation and load extract / extend
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  web,
    output logic [31:0] di,
    output logic [31:0] ext
);

    logic [31:0] sh;

    always_comb begin
        web = 4'h0;
        di  = wdata;
        case (funct3[1:0])
            2'b00: begin
                web = ~(4'b0001 << off);
                di  = {4{wdata[7:0]}};
            end
            2'b01: begin
                web = off[1] ? 4'b0011 : 4'b1100;
                di  = {2{wdata[15:0]}};
            end
            default: begin
                web = 4'b0000;
                di  = wdata;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0 before extending.
    always_comb begin
        sh  = rdata >> {off, 3'b000};
        ext = rdata;
        case (funct3)
            F3_B:    ext = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   ext = {24'h0, sh[7:0]};
            F3_H:    ext = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   ext = {16'h0, sh[15:0]};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - load/store unit to the DM1 SRAM; optional store forwarding under LSU_FWD_EN
module dm_lsu
    import lsu_pkg::*;
#(
    parameter int                 ADDR_W        = 14,
    parameter logic [ADDR_W-1:0]  SIM_END_WADDR = ADDR_W'(SIM_END_WADDR_DEF),
    parameter logic [31:0]        SIM_END_CODE  = SIM_END_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [3:0]        sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_di,
    input  logic [31:0]       sram_do,
    output logic              sim_done
);

    state_t            state;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] a_q;
    logic              accept, err, go;
    logic [ADDR_W-1:0] req_wa;
    logic [3:0]        st_web;
    logic [31:0]       st_di, ld_ext, rd_src;
    logic [31:0]       st_ext_unused, ld_di_unused;
    logic [3:0]        ld_web_unused;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign req_wa      = req_addr[ADDR_W+1:2];
    // Gating with rst keeps the combinational SRAM strobes quiet while reset is held.
    assign accept      = rst && req_valid && req_ready;
    assign go          = accept && !err;

    always_comb begin
        err = 1'b0;
        case (req_funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = req_addr[0];
            F3_W:    err = |req_addr[1:0];
            F3_BU:   err = req_we;
            F3_HU:   err = req_we | req_addr[0];
            default: err = 1'b1;
        endcase
    end

    lsu_align u_st_align (
        .funct3 (req_funct3),
        .off    (req_addr[1:0]),
        .wdata  (req_wdata),
        .rdata  (32'h0),
        .web    (st_web),
        .di     (st_di),
        .ext    (st_ext_unused)
    );

    lsu_align u_ld_align (
        .funct3 (f3_q),
        .off    (off_q),
        .wdata  (32'h0),
        .rdata  (rd_src),
        .web    (ld_web_unused),
        .di     (ld_di_unused),
        .ext    (ld_ext)
    );

    assign sram_cs  = go || (state == S_LOAD_WAIT);
    assign sram_oe  = (go && !req_we) || (state == S_LOAD_WAIT);
    assign sram_web = (go && req_we) ? st_web : 4'hF;
    assign sram_di  = (go && req_we) ? st_di : 32'h0;
    assign sram_a   = go ? req_wa : ((state == S_LOAD_WAIT) ? a_q : '0);

`ifdef LSU_FWD_EN
    logic [ADDR_W-1:0] fwd_a;
    logic [31:0]       fwd_d;
    logic [3:0]        fwd_m;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a <= '0;
            fwd_d <= 32'h0;
            fwd_m <= 4'h0;
        end else if (go && req_we) begin
            fwd_a <= req_wa;
            for (int i = 0; i < 4; i++) begin
                if (!st_web[i]) begin
                    fwd_d[8*i +: 8] <= st_di[8*i +: 8];
                end else if (fwd_a != req_wa) begin
                    fwd_d[8*i +: 8] <= 8'h0;
                end
            end
            fwd_m <= (fwd_a == req_wa) ? (fwd_m | ~st_web) : ~st_web;
        end
    end

    always_comb begin
        rd_src = sram_do;
        for (int i = 0; i < 4; i++) begin
            if (a_q == fwd_a && fwd_m[i]) rd_src[8*i +: 8] = fwd_d[8*i +: 8];
        end
    end
`else
    assign rd_src = sram_do;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            sim_done  <= 1'b0;
            off_q     <= 2'b00;
            f3_q      <= 3'b000;
            a_q       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        rsp_rdata <= 32'h0;
                        if (err) begin
                            state     <= S_ERR_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we) begin
                            state     <= S_STORE_RSP;
                            rsp_valid <= 1'b1;
                            if (req_funct3 == F3_W && req_wa == SIM_END_WADDR &&
                                req_wdata == SIM_END_CODE) begin
                                sim_done <= 1'b1;
                            end
                        end else begin
                            state <= S_LOAD_WAIT;
                            off_q <= req_addr[1:0];
                            f3_q  <= req_funct3;
                            a_q   <= req_wa;
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    state     <= S_LOAD_RSP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_ext;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - self-checking bench for dm_lsu with a behavioural SRAM and byte-level reference model
module tb_dm_lsu;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sram_cs, sram_oe;
    logic [3:0]  sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_di, sram_do;
    logic        sim_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] smem [0:16383];
    logic [7:0]  rmem [0:65535];

    dm_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web), .sram_a(sram_a),
        .sram_di(sram_di), .sram_do(sram_do), .sim_done(sim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_oe) sram_do <= smem[sram_a];
            for (int k = 0; k < 4; k++)
                if (!sram_web[k]) smem[sram_a][8*k +: 8] <= sram_di[8*k +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: byte-addressed 64 KB memory, RV32I access rules.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output logic [3:0] web, output int lat);
        int size;
        logic [31:0] v;
        logic [15:0] ba;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) er = 1'b1;
        else er = (we && f3[2]) || ((addr % size) != 0);
        rd = 32'h0;
        web = 4'hF;
        lat = (er || we) ? 1 : 2;
        if (!er) begin
            v = 32'h0;
            for (int k = 0; k < size; k++) begin
                ba = addr[15:0] + 16'(k);
                if (we) begin
                    rmem[ba] = wd[8*k +: 8];
                    web[ba[1:0]] = 1'b0;
                end else begin
                    v = v | (32'(rmem[ba]) << (8*k));
                end
            end
            if (!we) begin
                if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
                if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endtask

    // Issue one request starting at a negedge; returns at the negedge showing rsp_valid.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output logic [3:0] web, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        web = sram_web;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk); #1; lat++;
        end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        logic [3:0]  web;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic run_checked(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input string name);
        logic [31:0] erd, grd;
        logic        eer, ger;
        logic [3:0]  eweb, gweb;
        int          elat, glat;
        model(we, f3, addr, wd, erd, eer, eweb, elat);
        xact(we, f3, addr, wd, grd, ger, gweb, glat);
        chk({name, "_rdata"}, grd, erd);
        chk({name, "_err"}, 32'(ger), 32'(eer));
        chk({name, "_web"}, 32'(gweb), 32'(eweb));
        chk({name, "_lat"}, glat, elat);
    endtask

    initial begin
        logic [31:0] grd, drd;
        logic        ger, der;
        logic [3:0]  gweb, dweb;
        int          glat, dlat;
        bit          seen;

        for (int i = 0; i < 16384; i++) smem[i] = 32'h0;
        for (int i = 0; i < 65536; i++) rmem[i] = 8'h0;
        sram_do = 32'h0;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_cs_oe", {30'h0, sram_cs, sram_oe}, 32'h0);
        chk("rst_web", 32'(sram_web), 32'hF);
        chk("rst_a_di", {18'h0, sram_a} | sram_di, 32'h0);
        chk("rst_sim_done", 32'(sim_done), 32'd0);
        rst = 1'b1;

        tbl.push_back('{1'b1, 3'd2, 32'h8000,  32'h12345678, 32'h0,        1'b0, 4'h0, 1, "sw"});
        tbl.push_back('{1'b0, 3'd2, 32'h8000,  32'h0,        32'h12345678, 1'b0, 4'hF, 2, "lw"});
        tbl.push_back('{1'b1, 3'd0, 32'h8003,  32'h000000A5, 32'h0,        1'b0, 4'h7, 1, "sb"});
        tbl.push_back('{1'b0, 3'd0, 32'h8003,  32'h0,        32'hFFFFFFA5, 1'b0, 4'hF, 2, "lb"});
        tbl.push_back('{1'b0, 3'd4, 32'h8003,  32'h0,        32'h000000A5, 1'b0, 4'hF, 2, "lbu"});
        tbl.push_back('{1'b1, 3'd1, 32'h8001,  32'h0000FFFF, 32'h0,        1'b1, 4'hF, 1, "sh_mis"});
        tbl.push_back('{1'b0, 3'd2, 32'h8000,  32'h0,        32'hA5345678, 1'b0, 4'hF, 2, "lw_after_err"});
        tbl.push_back('{1'b1, 3'd1, 32'h8002,  32'h0000BEEF, 32'h0,        1'b0, 4'h3, 1, "sh_hi"});
        tbl.push_back('{1'b0, 3'd1, 32'h8002,  32'h0,        32'hFFFFBEEF, 1'b0, 4'hF, 2, "lh"});
        tbl.push_back('{1'b0, 3'd5, 32'h8002,  32'h0,        32'h0000BEEF, 1'b0, 4'hF, 2, "lhu"});
        tbl.push_back('{1'b0, 3'd2, 32'h18000, 32'h0,        32'hBEEF5678, 1'b0, 4'hF, 2, "lw_wrap"});
        tbl.push_back('{1'b0, 3'd2, 32'h8001,  32'h0,        32'h0,        1'b1, 4'hF, 1, "lw_mis"});
        tbl.push_back('{1'b0, 3'd3, 32'h8000,  32'h0,        32'h0,        1'b1, 4'hF, 1, "f3_011"});
        tbl.push_back('{1'b1, 3'd4, 32'h8000,  32'h0,        32'h0,        1'b1, 4'hF, 1, "store_bu"});
        tbl.push_back('{1'b1, 3'd1, 32'h8000,  32'h00001234, 32'h0,        1'b0, 4'hC, 1, "sh_lo"});
        tbl.push_back('{1'b0, 3'd0, 32'h8001,  32'h0,        32'h00000012, 1'b0, 4'hF, 2, "lb_pos"});

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, drd, der, dweb, dlat);
            xact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, grd, ger, gweb, glat);
            chk({tbl[i].name, "_rdata"}, grd, tbl[i].rd);
            chk({tbl[i].name, "_err"}, 32'(ger), 32'(tbl[i].er));
            chk({tbl[i].name, "_web"}, 32'(gweb), 32'(tbl[i].web));
            chk({tbl[i].name, "_lat"}, glat, tbl[i].lat);
        end

        run_checked(1'b1, 3'd2, 32'hFFFC, 32'h0, "sw_end_zero");
        chk("sim_done_after_zero", 32'(sim_done), 32'd0);
        run_checked(1'b1, 3'd2, 32'hFFFC, 32'hFFFFFFFF, "sw_end_code");
        chk("sim_done_set", 32'(sim_done), 32'd1);
        run_checked(1'b0, 3'd2, 32'h8000, 32'h0, "lw_post_end");
        chk("sim_done_held", 32'(sim_done), 32'd1);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000; #1;
        chk("b2b_accept1", 32'(req_ready), 32'd1);
        @(negedge clk); #1;
        chk("b2b_ready_wait", {30'h0, req_ready, rsp_valid}, 32'h0);
        @(negedge clk); #1;
        chk("b2b_ready_rsp", {30'h0, req_ready, rsp_valid}, 32'h1);
        chk("b2b_rdata1", rsp_rdata, 32'hBEEF1234);
        @(negedge clk); #1;
        chk("b2b_accept2", {30'h0, req_ready, rsp_valid}, 32'h2);
        @(negedge clk); req_valid = 1'b0; #1;
        chk("b2b_gap", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1;
        chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata2", rsp_rdata, 32'hBEEF1234);

        for (int i = 0; i < 250; i++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] raddr;
            rwe   = 1'($urandom_range(0, 1));
            rf3   = 3'($urandom_range(0, 7));
            raddr = ($urandom & 32'hFFFF_0000) | (32'h0200 + 32'($urandom_range(0, 31)));
            run_checked(rwe, rf3, raddr, $urandom, $sformatf("rnd%0d", i));
        end

        // Reset asserted while a load sits in LOAD_WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000; #1;
        chk("rstw_accept", 32'(req_ready), 32'd1);
        @(negedge clk); req_valid = 1'b0; #1;
        chk("rstw_cs_oe", {30'h0, sram_cs, sram_oe}, 32'h3);
        #1 rst = 1'b0;
        #1;
        chk("rstw_ready", 32'(req_ready), 32'd1);
        chk("rstw_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        chk("rstw_rdata", rsp_rdata, 32'h0);
        chk("rstw_cs_oe_clr", {30'h0, sram_cs, sram_oe}, 32'h0);
        chk("rstw_web", 32'(sram_web), 32'hF);
        chk("rstw_a_di", {18'h0, sram_a} | sram_di, 32'h0);
        chk("rstw_sim_done", 32'(sim_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rstw_no_rsp", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
